// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
// The header-tag state is only used when UART_CHANNEL_TAG_EN is defined.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TAG    = 2'd1,
    STREAM = 2'd2
  } arb_state_t;

  localparam logic [3:0] TAG_NIBBLE = 4'hA;
  localparam int         MAX_REQ    = 16;

  // Returns the first set index of req[n-1:0] starting at ptr and wrapping, or -1 when none is set.
  function automatic int rr_first_set(input logic [15:0] req, input logic [3:0] ptr, input int n);
    int         result;
    logic [3:0] j;
    result = -1;
    j      = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = 4'((int'(ptr) + k) % n);
        if (req[j]) result = int'(j);
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin priority picker; shared by the TX arbiter and the RX dispatch side.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int first_idx;

  always_comb begin
    first_idx = rr_first_set(16'(req), 4'(ptr), NUM_REQ);
  end

  assign found = (first_idx >= 0);
  assign idx   = IDX_W'(first_idx);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX push interface among NUM_REQ byte-stream requesters.
// Define UART_CHANNEL_TAG_EN to prefix every burst with a {4'hA, requester id} header byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                 UART_SRC_CK,
  input  logic                 UART_RST_N,
  input  logic [NUM_REQ-1:0]   REQ_VALID,
  input  logic [8*NUM_REQ-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]   REQ_LAST,
  output logic [NUM_REQ-1:0]   REQ_READY,
  output logic [7:0]           TX_REG,
  output logic                 PUSH_TX,
  input  logic                 TX_FULL,
  output logic [IDX_W-1:0]     GRANT_ID,
  output logic                 BUSY
);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [7:0]       cnt;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             accept;
  logic             release_burst;
  logic [7:0]       cnt_next;

  uart_rr_picker #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req  (REQ_VALID),
    .ptr  (ptr),
    .found(pick_found),
    .idx  (pick_idx)
  );

  // Push path is a pure mux of the holder's request so a byte leaves in the cycle it is offered.
  always_comb begin
    REQ_READY = '0;
    TX_REG    = '0;
    PUSH_TX   = 1'b0;
    case (state)
      STREAM: begin
        TX_REG              = REQ_DATA[GRANT_ID*8 +: 8];
        PUSH_TX             = REQ_VALID[GRANT_ID] & ~TX_FULL;
        REQ_READY[GRANT_ID] = PUSH_TX;
      end
`ifdef UART_CHANNEL_TAG_EN
      TAG: begin
        TX_REG  = {TAG_NIBBLE, 4'(GRANT_ID)};
        PUSH_TX = ~TX_FULL;
      end
`endif
      default: ;
    endcase
  end

  assign accept        = (state == STREAM) & PUSH_TX;
  assign cnt_next      = cnt + 8'd1;
  assign release_burst = accept & (REQ_LAST[GRANT_ID] | (cnt_next == 8'(MAX_BURST)));
  assign BUSY          = (state != IDLE);

  always_ff @(posedge UART_SRC_CK or negedge UART_RST_N) begin
    if (!UART_RST_N) begin
      state    <= IDLE;
      GRANT_ID <= '0;
      ptr      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            GRANT_ID <= pick_idx;
            cnt      <= '0;
`ifdef UART_CHANNEL_TAG_EN
            state    <= TAG;
`else
            state    <= STREAM;
`endif
          end
        end
`ifdef UART_CHANNEL_TAG_EN
        TAG: begin
          if (!TX_FULL) state <= STREAM;
        end
`endif
        STREAM: begin
          if (accept) begin
            cnt <= cnt_next;
            if (release_burst) begin
              ptr   <= (GRANT_ID == IDX_W'(NUM_REQ - 1)) ? '0 : GRANT_ID + 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table vectors, directed corner sequences and
// randomized traffic compared against a burst-level behavioural model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 16;
  localparam int IDX_W     = 2;
`ifdef UART_CHANNEL_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]   req_last  = '0;
  logic                 tx_full   = 1'b0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_reg;
  logic                 push_tx;
  logic [IDX_W-1:0]     grant_id;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: current holder (-1 when idle), pending header, bytes taken this burst, next search start.
  int m_holder = -1;
  bit m_tag    = 1'b0;
  int m_count  = 0;
  int m_next   = 0;

  logic             s_push, s_busy;
  logic [7:0]       s_tx;
  logic [3:0]       s_ready;
  logic [IDX_W-1:0] s_gid;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        full;
    logic        exp_push;
    logic [7:0]  exp_tx;
    logic [3:0]  exp_ready;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .MAX_BURST(MAX_BURST),
    .IDX_W    (IDX_W)
  ) dut (
    .UART_SRC_CK(clk),
    .UART_RST_N (rst_n),
    .REQ_VALID  (req_valid),
    .REQ_DATA   (req_data),
    .REQ_LAST   (req_last),
    .REQ_READY  (req_ready),
    .TX_REG     (tx_reg),
    .PUSH_TX    (push_tx),
    .TX_FULL    (tx_full),
    .GRANT_ID   (grant_id),
    .BUSY       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_holder = -1;
    m_tag    = 1'b0;
    m_count  = 0;
    m_next   = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    if (m_holder < 0) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (m_holder < 0 && req_valid[(m_next + i) % NUM_REQ]) begin
          m_holder = (m_next + i) % NUM_REQ;
          m_tag    = TAG_EN;
          m_count  = 0;
        end
      end
    end else if (m_tag) begin
      if (!tx_full) m_tag = 1'b0;
    end else if (req_valid[m_holder] && !tx_full) begin
      m_count++;
      if (req_last[m_holder] || m_count == MAX_BURST) begin
        m_next   = (m_holder + 1) % NUM_REQ;
        m_holder = -1;
      end
    end
  endtask

  task automatic checkOutput();
    logic       e_push, e_busy;
    logic [7:0] e_tx;
    logic [3:0] e_ready;
    logic [1:0] e_gid;
    s_push  = push_tx;
    s_tx    = tx_reg;
    s_ready = req_ready;
    s_busy  = busy;
    s_gid   = grant_id;
    e_push  = 1'b0;
    e_tx    = 8'h00;
    e_ready = 4'h0;
    e_busy  = 1'b0;
    e_gid   = 2'd0;
    if (m_holder >= 0) begin
      e_busy = 1'b1;
      e_gid  = 2'(m_holder);
      if (m_tag) begin
        e_push = !tx_full;
        e_tx   = 8'hA0 | 8'(m_holder);
      end else begin
        e_tx   = req_data[m_holder*8 +: 8];
        e_push = req_valid[m_holder] && !tx_full;
        if (e_push) e_ready[m_holder] = 1'b1;
      end
    end
    check("cycle_outputs", 32'({s_busy, s_push, s_ready, s_tx, (s_busy ? s_gid : 2'd0)}),
          32'({e_busy, e_push, e_ready, e_tx, e_gid}));
  endtask

  // Called at posedge+1; drives one cycle, checks mid-cycle, and returns at the next posedge+1.
  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                               input logic f);
    req_valid = v;
    req_data  = d;
    req_last  = l;
    tx_full   = f;
    #4;
    checkOutput();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_full   = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic void add_vec(logic [3:0] v, logic [31:0] d, logic [3:0] l, logic f,
                                  logic ep, logic [7:0] et, logic [3:0] er, logic eb);
    vec_t x;
    x.valid     = v;
    x.data      = d;
    x.last      = l;
    x.full      = f;
    x.exp_push  = ep;
    x.exp_tx    = et;
    x.exp_ready = er;
    x.exp_busy  = eb;
    tbl.push_back(x);
  endfunction

  function automatic logic [31:0] d2(logic [7:0] b);
    return {8'hEE, b, 8'hEE, 8'hEE};
  endfunction

  initial begin
    int         k, n0, next_gid, gap, full_push;
    int         cnt[NUM_REQ];
    int         order[$];
    logic [7:0] got[$];
    logic       prev_busy;
    logic [31:0] d;
    logic [3:0]  l;
    logic        f;
    int          exp_order[5];

    exp_order = '{0, 1, 2, 3, 0};

    // Requester 2 sends 0x10..0x14 with a one-cycle TX_FULL stall after the second byte.
    add_vec(4'b0100, d2(8'h10), 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0);
    if (TAG_EN) add_vec(4'b0100, d2(8'h10), 4'b0000, 1'b0, 1'b1, 8'hA2, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      add_vec(4'b0100, d2(8'(8'h10 + i)), (i == 4) ? 4'b1111 : 4'b1011, 1'b0,
              1'b1, 8'(8'h10 + i), 4'b0100, 1'b1);
      if (i == 1) add_vec(4'b0100, d2(8'h12), 4'b1011, 1'b1, 1'b0, 8'h12, 4'b0000, 1'b1);
    end
    add_vec(4'b0000, d2(8'hEE), 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0);

    $display("[TB] reset values");
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({push_tx, tx_reg, req_ready, busy, grant_id}), 32'h0);
    model_reset();
    rst_n = 1'b1;

    $display("[TB] table vectors");
    for (int i = 0; i < tbl.size(); i++) begin
      req_valid = tbl[i].valid;
      req_data  = tbl[i].data;
      req_last  = tbl[i].last;
      tx_full   = tbl[i].full;
      #4;
      check($sformatf("vec%0d", i), 32'({push_tx, tx_reg, req_ready, busy}),
            32'({tbl[i].exp_push, tbl[i].exp_tx, tbl[i].exp_ready, tbl[i].exp_busy}));
      model_step();
      @(posedge clk);
      #1;
    end

    $display("[TB] reset mid-burst");
    k = 0;
    for (int c = 0; c < 10 && k < 2; c++) begin
      applyStimulus(4'b0010, {8'h00, 8'h00, 8'(8'h21 + k), 8'h00}, 4'b0000, 1'b0);
      if (s_ready[1]) k++;
    end
    req_data = {8'h00, 8'h00, 8'h23, 8'h00};
    #2 rst_n = 1'b0;
    #1;
    check("reset_midburst", 32'({push_tx, tx_reg, req_ready, busy, grant_id}), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    check("reset_held", 32'({push_tx, tx_reg, req_ready, busy, grant_id}), 32'h0);
    rst_n = 1'b1;
    applyStimulus(4'b1001, 32'h0, 4'b1001, 1'b0);
    applyStimulus(4'b1001, 32'h0, 4'b1001, 1'b0);
    check("grant_after_reset", 32'({s_busy, s_gid}), 32'({1'b1, 2'd0}));

    $display("[TB] round-robin order");
    do_reset();
    cnt = '{0, 0, 0, 0};
    prev_busy = 1'b0;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        d[i*8 +: 8] = {4'(i), 4'(cnt[i])};
        l[i]        = (cnt[i] % 3 == 2);
      end
      applyStimulus(4'b1111, d, l, 1'b0);
      for (int i = 0; i < NUM_REQ; i++) if (s_ready[i]) cnt[i]++;
      if (s_busy && !prev_busy) order.push_back(int'(s_gid));
      prev_busy = s_busy;
    end
    check("rr_grant_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < order.size() && i < 5; i++)
      check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));

    $display("[TB] forced release at MAX_BURST");
    do_reset();
    n0 = 0;
    k = 0;
    next_gid = -1;
    for (int c = 0; c < 60 && next_gid < 0; c++) begin
      applyStimulus(4'b0011, {8'h00, 8'h00, 8'(8'h80 + k), 8'(n0)}, 4'b0010, 1'b0);
      if (s_ready[0]) n0++;
      if (s_ready[1]) k++;
      if (s_busy && s_gid != 2'd0) next_gid = int'(s_gid);
    end
    check("max_burst_len", 32'(n0), 32'(MAX_BURST));
    check("next_after_max", 32'(next_gid), 32'd1);

    $display("[TB] TX_FULL stall");
    do_reset();
    k = 0;
    full_push = 0;
    for (int c = 0; c < 20; c++) begin
      f = (c >= 4 && c < 8);
      applyStimulus((k < 8) ? 4'b1000 : 4'b0000, {8'(8'h30 + k), 24'h0},
                    (k == 7) ? 4'b1000 : 4'b0000, f);
      if (s_ready[3]) begin
        got.push_back(s_tx);
        k++;
      end
      if (f && s_push) full_push++;
    end
    check("stall_byte_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < got.size() && i < 8; i++)
      check($sformatf("stall_byte%0d", i), 32'(got[i]), 32'(8'h30 + i));
    check("push_while_full", 32'(full_push), 32'd0);

    $display("[TB] LAST on final allowed byte");
    do_reset();
    k = 0;
    gap = 0;
    next_gid = -1;
    for (int c = 0; c < 40 && next_gid < 0; c++) begin
      applyStimulus((c >= 1) ? 4'b1110 : 4'b0010, {8'h55, 8'h55, 8'(8'h40 + k), 8'h55},
                    (k == 15) ? 4'b1110 : 4'b1100, 1'b0);
      if (s_ready[1]) k++;
      if (k == 16) begin
        if (!s_busy) gap++;
        else if (gap > 0) next_gid = int'(s_gid);
      end
    end
    check("last16_bytes", 32'(k), 32'd16);
    check("last16_idle_gap", 32'(gap), 32'd1);
    check("last16_next_grant", 32'(next_gid), 32'd2);

    $display("[TB] randomized traffic");
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM_REQ; i++) l[i] = ($urandom_range(0, 9) == 0);
      applyStimulus(4'($urandom), $urandom, l, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
